// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - shared state encoding, condition codes and compare-opcode range
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // TST/TEQ/CMP/CMN only update flags, never Rd
    localparam logic [3:0] CMP_OP_LO = 4'b1000;
    localparam logic [3:0] CMP_OP_HI = 4'b1011;

    function automatic logic is_compare_op(input logic [3:0] op);
        return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
    endfunction

endpackage

// File: rtl/cpu_controller_cond_check.sv
// rtl/cpu_controller_cond_check.sv - ARM-style condition evaluation against {N,Z,C,V}
module cond_check
    import cpu_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = nzcv;

    // decode the condition field into a single pass/fail bit
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle fetch/decode/execute/writeback control FSM
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CP,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  nzcv,
    output logic        writePC,
    output logic        pcSel,
    output logic        writeIR,
    output logic        writeReg,
    output logic        writeNZCV,
    output logic [3:0]  aluOp,
    output logic        useImm,
    output logic        done,
    output logic [2:0]  state
);

    state_t r_state;
    state_t w_next_state;
    logic   w_pass;
    logic   w_unused_ir_bits;

    // low IR bits are operand fields that belong to the datapath
    assign w_unused_ir_bits = ^IR[19:0];

    cond_check u_cond_check (
        .cond (IR[31:28]),
        .nzcv (nzcv),
        .pass (w_pass)
    );

    // ALU controls follow IR directly; forced low while in reset so every output clears
    assign aluOp  = reset ? IR[24:21] : 4'b0000;
    assign useImm = reset ? IR[25]    : 1'b0;
    assign done   = (r_state == ST_HALT);
    assign state  = r_state;

    // state register, asynchronously cleared to IDLE
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state selection and per-state strobes
    always_comb begin
        w_next_state = r_state;
        writePC      = 1'b0;
        pcSel        = 1'b0;
        writeIR      = 1'b0;
        writeReg     = 1'b0;
        writeNZCV    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                writeIR      = 1'b1;
                writePC      = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (IR == HALT_WORD) begin
                    w_next_state = ST_HALT;
                end else if (!w_pass) begin
                    w_next_state = ST_FETCH;
                end else if (IR[27:26] == 2'b00) begin
                    w_next_state = ST_EXEC;
                end else if (IR[27:25] == 3'b101) begin
                    w_next_state = ST_BRANCH;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_WB;
            end
            ST_WB: begin
                writeReg     = ~is_compare_op(IR[24:21]);
                writeNZCV    = IR[20];
                w_next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                writePC      = 1'b1;
                pcSel        = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic        CP;
    logic        reset;
    logic [31:0] IR;
    logic [3:0]  nzcv;
    logic        writePC, pcSel, writeIR, writeReg, writeNZCV, useImm, done;
    logic [3:0]  aluOp;
    logic [2:0]  state;

    int total;
    int bad;

    logic [3:0] tc_cond  [0:9];
    logic [3:0] tc_flags [0:9];
    logic       tc_take  [0:9];

    cpu_controller #(.HALT_WORD(32'hFFFF_FFFF)) dut (
        .CP        (CP),
        .reset     (reset),
        .IR        (IR),
        .nzcv      (nzcv),
        .writePC   (writePC),
        .pcSel     (pcSel),
        .writeIR   (writeIR),
        .writeReg  (writeReg),
        .writeNZCV (writeNZCV),
        .aluOp     (aluOp),
        .useImm    (useImm),
        .done      (done),
        .state     (state)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // strobe vector {writePC, pcSel, writeIR, writeReg, writeNZCV, done}
    function automatic logic [5:0] strobes();
        return {writePC, pcSel, writeIR, writeReg, writeNZCV, done};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        IR    = 32'h0;
        nzcv  = 4'h0;
        repeat (3) @(posedge CP);
        @(negedge CP);
        total++;
        if (state !== 3'd0 || strobes() !== 6'b0 || aluOp !== 4'd0 || useImm !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: state=%0d strobes=%b aluOp=%b useImm=%b required state=0 all zero",
                     state, strobes(), aluOp, useImm);
        end
        reset = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || strobes() !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle: state=%0d strobes=%b required state=0 strobes=000000", state, strobes());
        end
        @(negedge CP);
        total++;
        if (state !== 3'd1 || strobes() !== 6'b101000) begin
            bad++;
            $display("FAIL first_fetch: state=%0d strobes=%b required state=1 strobes=101000", state, strobes());
        end
    endtask

    task automatic test_add();
        IR   = 32'hE0810002;
        nzcv = 4'b0000;
        @(negedge CP);
        total++;
        if (state !== 3'd2 || strobes() !== 6'b0) begin
            bad++;
            $display("FAIL add_decode: state=%0d strobes=%b required state=2 strobes=000000", state, strobes());
        end
        @(negedge CP);
        total++;
        if (state !== 3'd3 || strobes() !== 6'b0 || aluOp !== 4'b0100 || useImm !== 1'b0) begin
            bad++;
            $display("FAIL add_exec: state=%0d strobes=%b aluOp=%b useImm=%b required 3 000000 0100 0",
                     state, strobes(), aluOp, useImm);
        end
        @(negedge CP);
        total++;
        if (state !== 3'd4 || strobes() !== 6'b000100 || aluOp !== 4'b0100) begin
            bad++;
            $display("FAIL add_wb: state=%0d strobes=%b aluOp=%b required 4 000100 0100", state, strobes(), aluOp);
        end
        @(negedge CP);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL add_refetch: state=%0d required 1", state);
        end
    endtask

    task automatic test_cmp();
        IR   = 32'hE3500005;
        nzcv = 4'b0000;
        @(negedge CP);
        @(negedge CP);
        total++;
        if (state !== 3'd3 || aluOp !== 4'b1010 || useImm !== 1'b1) begin
            bad++;
            $display("FAIL cmp_exec: state=%0d aluOp=%b useImm=%b required 3 1010 1", state, aluOp, useImm);
        end
        @(negedge CP);
        total++;
        if (state !== 3'd4 || strobes() !== 6'b000010 || aluOp !== 4'b1010 || useImm !== 1'b1) begin
            bad++;
            $display("FAIL cmp_wb: state=%0d strobes=%b aluOp=%b useImm=%b required 4 000010 1010 1",
                     state, strobes(), aluOp, useImm);
        end
        @(negedge CP);
    endtask

    task automatic test_beq();
        IR   = 32'h0A000003;
        nzcv = 4'b0000;
        @(negedge CP);
        total++;
        if (state !== 3'd2 || strobes() !== 6'b0) begin
            bad++;
            $display("FAIL beq_nt_decode: state=%0d strobes=%b required 2 000000", state, strobes());
        end
        @(negedge CP);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL beq_nt_next: state=%0d required 1", state);
        end
        nzcv = 4'b0100;
        @(negedge CP);
        @(negedge CP);
        total++;
        if (state !== 3'd5 || strobes() !== 6'b110000) begin
            bad++;
            $display("FAIL beq_taken: state=%0d strobes=%b required 5 110000", state, strobes());
        end
        @(negedge CP);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL beq_refetch: state=%0d required 1", state);
        end
    endtask

    task automatic test_conditions();
        tc_cond[0] = 4'b1000; tc_flags[0] = 4'b0010; tc_take[0] = 1'b1;
        tc_cond[1] = 4'b1001; tc_flags[1] = 4'b0010; tc_take[1] = 1'b0;
        tc_cond[2] = 4'b1010; tc_flags[2] = 4'b1001; tc_take[2] = 1'b1;
        tc_cond[3] = 4'b1011; tc_flags[3] = 4'b1001; tc_take[3] = 1'b0;
        tc_cond[4] = 4'b1100; tc_flags[4] = 4'b0000; tc_take[4] = 1'b1;
        tc_cond[5] = 4'b1101; tc_flags[5] = 4'b0000; tc_take[5] = 1'b0;
        tc_cond[6] = 4'b1110; tc_flags[6] = 4'b1111; tc_take[6] = 1'b1;
        tc_cond[7] = 4'b1111; tc_flags[7] = 4'b1111; tc_take[7] = 1'b0;
        tc_cond[8] = 4'b0001; tc_flags[8] = 4'b0100; tc_take[8] = 1'b0;
        tc_cond[9] = 4'b0110; tc_flags[9] = 4'b0001; tc_take[9] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IR   = {tc_cond[i], 4'b1010, 24'h000010};
            nzcv = tc_flags[i];
            @(negedge CP);
            @(negedge CP);
            total++;
            if (state !== (tc_take[i] ? 3'd5 : 3'd1)) begin
                bad++;
                $display("FAIL cond_%b_flags_%b: state=%0d required %0d",
                         tc_cond[i], tc_flags[i], state, tc_take[i] ? 5 : 1);
            end
            if (tc_take[i]) @(negedge CP);
        end
    endtask

    task automatic test_ldr();
        IR   = 32'hE5912000;
        nzcv = 4'b0000;
        @(negedge CP);
        total++;
        if (state !== 3'd2 || writeReg !== 1'b0 || writeNZCV !== 1'b0) begin
            bad++;
            $display("FAIL ldr_decode: state=%0d writeReg=%b writeNZCV=%b required 2 0 0", state, writeReg, writeNZCV);
        end
        @(negedge CP);
        total++;
        if (state !== 3'd1 || writeReg !== 1'b0 || writeNZCV !== 1'b0) begin
            bad++;
            $display("FAIL ldr_next: state=%0d writeReg=%b writeNZCV=%b required 1 0 0", state, writeReg, writeNZCV);
        end
    endtask

    task automatic test_reset_mid();
        IR   = 32'hE0810002;
        nzcv = 4'b0000;
        @(negedge CP);
        @(negedge CP);
        #2 reset = 1'b0;
        #1;
        total++;
        if (state !== 3'd0 || strobes() !== 6'b0 || aluOp !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: state=%0d strobes=%b aluOp=%b required 0 000000 0000", state, strobes(), aluOp);
        end
        @(negedge CP);
        reset = 1'b1;
        @(negedge CP);
        total++;
        if (state !== 3'd1 || writeIR !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_restart: state=%0d writeIR=%b required 1 1", state, writeIR);
        end
    endtask

    task automatic test_halt();
        int held;
        IR   = 32'hFFFFFFFF;
        nzcv = 4'b0000;
        @(negedge CP);
        total++;
        if (state !== 3'd2 || done !== 1'b0) begin
            bad++;
            $display("FAIL halt_decode: state=%0d done=%b required 2 0", state, done);
        end
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CP);
            if (done === 1'b1 && state === 3'd6 && writePC === 1'b0 && writeIR === 1'b0) held++;
        end
        total++;
        if (held !== 20) begin
            bad++;
            $display("FAIL halt_hold: cycles with done=1 state=6 got %0d required 20", held);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || state !== 3'd0 || aluOp !== 4'd0 || useImm !== 1'b0) begin
            bad++;
            $display("FAIL halt_async_reset: done=%b state=%0d aluOp=%b useImm=%b required 0 0 0000 0",
                     done, state, aluOp, useImm);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_cmp();
        test_beq();
        test_conditions();
        test_ldr();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction word that stops the machine.
REQ-002 CP  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 IR  input  32  latched instruction from the datapath IR register.
REQ-005 nzcv  input  4  registered flags {N,Z,C,V} from the datapath.
REQ-006 writePC  output  1  PC load strobe.
REQ-007 pcSel  output  1  PC source: 0 = PC+4, 1 = branch target.
REQ-008 writeIR  output  1  IR load strobe.
REQ-009 writeReg  output  1  register-file write strobe for Rd.
REQ-010 writeNZCV  output  1  flag register load strobe.
REQ-011 aluOp  output  4  ALU opcode, equals IR[24:21].
REQ-012 useImm  output  1  B operand is the immediate, equals IR[25].
REQ-013 done  output  1  machine halted.
REQ-014 state  output  3  current FSM state, for debug and waveform.

Function
REQ-015 The FSM SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, BRANCH=5, HALT=6, registered on CP.
REQ-016 Transitions SHALL be: IDLE->FETCH; FETCH->DECODE; EXEC->WB; WB->FETCH; BRANCH->FETCH; HALT->HALT.
REQ-017 In DECODE, the next state SHALL follow this priority: IR==HALT_WORD -> HALT; condition false -> FETCH; IR[27:26]==00 -> EXEC; IR[27:25]==101 -> BRANCH; otherwise FETCH (unsupported instruction = NOP).
REQ-018 The condition IR[31:28] SHALL evaluate as ARM: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-019 FETCH SHALL assert writeIR=1 and writePC=1 with pcSel=0 for exactly one cycle.
REQ-020 WB SHALL assert writeReg=1 unless IR[24:21] is in 1000..1011 (TST/TEQ/CMP/CMN).
REQ-021 WB SHALL assert writeNZCV=IR[20].
REQ-022 BRANCH SHALL assert writePC=1 and pcSel=1 for one cycle.
REQ-023 All strobes SHALL be 0 in IDLE, DECODE, EXEC and HALT, and every strobe not named in REQ-019..022 SHALL be 0 in the other states.
REQ-024 aluOp and useImm SHALL be combinational from IR and stable throughout EXEC and WB.
REQ-025 done SHALL be 1 if and only if state==HALT, and SHALL stay 1 until reset.
REQ-026 Latency SHALL be 4 cycles per data-processing instruction, 3 per taken branch, and 2 per skipped, NOP or failed-condition instruction.
REQ-027 Flags written in WB SHALL be the ones evaluated by the next instruction's DECODE; no bypass is needed.

Reset
REQ-028 While reset=0, state SHALL be IDLE and all outputs 0, asynchronously, including reset asserted mid-instruction or in HALT.
REQ-029 The first FETCH SHALL occur on the second rising edge after reset is released.

Structure
REQ-030 A shared package SHALL hold the state encoding, the condition-code constants, and the compare-opcode range 1000..1011.
REQ-031 Condition evaluation SHALL be one combinational sub-module, cond_check (inputs cond[3:0] and nzcv, output pass).

Verification
REQ-032 Reset: hold reset=0 for 3 cycles, then release -> state 0 for one cycle, then writeIR=writePC=1 with state=1.
REQ-033 IR=32'hE0810002 (ADD AL) -> states 1,2,3,4; aluOp=0100; useImm=0; writeReg=1 and writeNZCV=0 in WB.
REQ-034 IR=32'hE3500005 (CMP #5, S=1) -> in WB writeReg=0 and writeNZCV=1; aluOp=1010; useImm=1.
REQ-035 IR=32'h0A000003 (BEQ): nzcv=0000 -> DECODE goes to FETCH with no writes; nzcv=0100 -> BRANCH with writePC=1 and pcSel=1.
REQ-036 IR=32'hFFFFFFFF -> done=1 from the cycle after DECODE and held for 20 cycles; driving reset=0 in HALT -> done=0 without waiting for a CP edge.
REQ-037 IR=32'hE5912000 (LDR, unsupported) -> DECODE goes to FETCH, and writeReg and writeNZCV stay 0.
